// File: rtl/pmc_pkg.sv
// rtl/pmc_pkg.sv - shared states, mode and status-LED field definitions for pipe_mode_ctrl
package pmc_pkg;

    typedef enum logic [1:0] {
        CFG_START = 2'd0,
        CFG_WAIT  = 2'd1,
        ACTIVE    = 2'd2,
        FLUSH     = 2'd3
    } pmc_state_e;

    localparam int MODE_PASSTHROUGH = 0;

    localparam int LED_FILT_LSB = 0;
    localparam int LED_FILT_W   = 4;
    localparam int LED_MODE_LSB = 4;
    localparam int LED_MODE_W   = 3;
    localparam int LED_RUN_BIT  = 7;

endpackage

// File: rtl/btn_pulse.sv
// rtl/btn_pulse.sv - debounced button turned into a one-cycle press pulse on its rising edge
module btn_pulse #(
    parameter int DB_COUNT = 500_000
) (
    input  logic i_sysclk,
    input  logic i_rstn,
    input  logic i_btn,
    output logic o_pulse
);

    logic level;
    logic level_q;
    logic pulse_q;

    debounce #(
        .DB_COUNT(DB_COUNT)
    ) u_debounce (
        .i_sysclk(i_sysclk),
        .i_rstn  (i_rstn),
        .i_raw   (i_btn),
        .o_level (level)
    );

    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level;
            pulse_q <= level & ~level_q;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/debounce.sv
// rtl/debounce.sv - two-flop synchroniser followed by a stable-count debounce filter
module debounce #(
    parameter int DB_COUNT = 500_000
) (
    input  logic i_sysclk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DB_COUNT + 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Level only follows the input after it has differed for DB_COUNT consecutive cycles.
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q <= i_raw;
            s2_q <= s1_q;
            if (s2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DB_COUNT - 1)) begin
                level_q <= s2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/pipe_mode_ctrl.sv
// rtl/pipe_mode_ctrl.sv - camera config start, mode/filter selection applied at start-of-frame behind a flush; PMC_CFG_WATCHDOG_EN adds config retry
module pipe_mode_ctrl
    import pmc_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int NUM_FILTERS = 4,
    parameter int DB_COUNT    = 500_000,
    parameter int MW          = $clog2(NUM_MODES)
`ifdef PMC_CFG_WATCHDOG_EN
    ,
    parameter int CFG_TIMEOUT = 2_500_000
`endif
) (
    input  logic                   i_sysclk,
    input  logic                   i_rstn,
    input  logic                   i_sof,
    input  logic                   i_cfg_done,
    input  logic                   i_btn_next,
    input  logic                   i_btn_prev,
    input  logic [NUM_FILTERS-1:0] i_sw_filter,
    output logic                   o_cfg_start,
    output logic [MW-1:0]          o_mode,
    output logic [NUM_FILTERS-1:0] o_filter_en,
    output logic                   o_pipe_flush,
    output logic [7:0]             o_status_leds
);

    localparam logic [MW-1:0] MODE_MAX = MW'(NUM_MODES - 1);

    logic                   next_p;
    logic                   prev_p;
    logic [NUM_FILTERS-1:0] sw_s1_q;
    logic [NUM_FILTERS-1:0] sw_s2_q;
    logic [MW-1:0]          pend_mode_q;
    logic [MW-1:0]          pend_mode_d;
    logic [NUM_FILTERS-1:0] pend_en_q;
    logic [NUM_FILTERS-1:0] pend_en_d;

    pmc_state_e             state_q;
    logic                   cfg_start_q;
    logic                   flush_q;
    logic [MW-1:0]          mode_q;
    logic [NUM_FILTERS-1:0] filt_q;
    logic                   change;
    logic                   run_led;
    logic [7:0]             leds;

    btn_pulse #(.DB_COUNT(DB_COUNT)) u_btn_next (
        .i_sysclk(i_sysclk),
        .i_rstn  (i_rstn),
        .i_btn   (i_btn_next),
        .o_pulse (next_p)
    );

    btn_pulse #(.DB_COUNT(DB_COUNT)) u_btn_prev (
        .i_sysclk(i_sysclk),
        .i_rstn  (i_rstn),
        .i_btn   (i_btn_prev),
        .o_pulse (prev_p)
    );

    // Simultaneous next+prev cancel out; passthrough forces every filter off.
    always_comb begin
        pend_mode_d = pend_mode_q;
        if (next_p && !prev_p) begin
            pend_mode_d = (pend_mode_q == MODE_MAX) ? '0 : pend_mode_q + 1'b1;
        end else if (prev_p && !next_p) begin
            pend_mode_d = (pend_mode_q == '0) ? MODE_MAX : pend_mode_q - 1'b1;
        end
        pend_en_d = (pend_mode_d == MW'(MODE_PASSTHROUGH)) ? '0 : sw_s2_q;
    end

    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            pend_mode_q <= '0;
            pend_en_q   <= '0;
        end else begin
            sw_s1_q     <= i_sw_filter;
            sw_s2_q     <= sw_s1_q;
            pend_mode_q <= pend_mode_d;
            pend_en_q   <= pend_en_d;
        end
    end

    assign change = (pend_mode_q != mode_q) || (pend_en_q != filt_q);

`ifdef PMC_CFG_WATCHDOG_EN
    localparam int WCW = ($clog2(CFG_TIMEOUT + 1) > 23) ? $clog2(CFG_TIMEOUT + 1) : 23;
    logic [WCW-1:0] wd_cnt_q;
    logic [3:0]     retry_q;
`endif

    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            state_q     <= CFG_START;
            cfg_start_q <= 1'b0;
            flush_q     <= 1'b0;
            mode_q      <= '0;
            filt_q      <= '0;
`ifdef PMC_CFG_WATCHDOG_EN
            wd_cnt_q    <= '0;
            retry_q     <= '0;
`endif
        end else begin
            cfg_start_q <= 1'b0;
`ifdef PMC_CFG_WATCHDOG_EN
            wd_cnt_q    <= (state_q == CFG_WAIT) ? wd_cnt_q + 1'b1 : '0;
`endif
            case (state_q)
                CFG_START: begin
                    state_q     <= CFG_WAIT;
                    cfg_start_q <= 1'b1;
                end
                CFG_WAIT: begin
                    if (i_cfg_done) begin
                        state_q <= ACTIVE;
                    end
`ifdef PMC_CFG_WATCHDOG_EN
                    else if (wd_cnt_q == WCW'(CFG_TIMEOUT)) begin
                        state_q <= CFG_START;
                        if (retry_q != 4'hF) begin
                            retry_q <= retry_q + 1'b1;
                        end
                    end
`endif
                end
                ACTIVE: begin
                    if (change) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (i_sof) begin
                        state_q <= ACTIVE;
                        flush_q <= 1'b0;
                        mode_q  <= pend_mode_q;
                        filt_q  <= pend_en_q;
                    end
                end
                default: state_q <= CFG_START;
            endcase
        end
    end

`ifdef PMC_CFG_WATCHDOG_EN
    assign run_led = (state_q == ACTIVE) || (state_q == FLUSH) ||
                     ((state_q == CFG_WAIT) && (retry_q != 4'h0) && wd_cnt_q[22]);
`else
    assign run_led = (state_q == ACTIVE) || (state_q == FLUSH);
`endif

    for (genvar i = 0; i < LED_FILT_W; i++) begin : g_led_filt
        if (i < NUM_FILTERS) begin : g_on
            assign leds[LED_FILT_LSB + i] = filt_q[i];
        end else begin : g_off
            assign leds[LED_FILT_LSB + i] = 1'b0;
        end
    end

    for (genvar i = 0; i < LED_MODE_W; i++) begin : g_led_mode
        if (i < MW) begin : g_on
            assign leds[LED_MODE_LSB + i] = mode_q[i];
        end else begin : g_off
            assign leds[LED_MODE_LSB + i] = 1'b0;
        end
    end

    assign leds[LED_RUN_BIT] = run_led;

    assign o_cfg_start   = cfg_start_q;
    assign o_mode        = mode_q;
    assign o_filter_en   = filt_q;
    assign o_pipe_flush  = flush_q;
    assign o_status_leds = leds;

endmodule

// File: tb/tb_pipe_mode_ctrl.sv
// tb/tb_pipe_mode_ctrl.sv - directed self-checking bench for pipe_mode_ctrl
module tb_pipe_mode_ctrl;

    localparam int NM  = 4;
    localparam int NF  = 4;
    localparam int DBC = 16;

    logic          i_sysclk    = 1'b0;
    logic          i_rstn      = 1'b0;
    logic          i_sof       = 1'b0;
    logic          i_cfg_done  = 1'b0;
    logic          i_btn_next  = 1'b0;
    logic          i_btn_prev  = 1'b0;
    logic [NF-1:0] i_sw_filter = '0;
    logic          o_cfg_start;
    logic [1:0]    o_mode;
    logic [NF-1:0] o_filter_en;
    logic          o_pipe_flush;
    logic [7:0]    o_status_leds;

    int n_pass  = 0;
    int n_total = 0;

    pipe_mode_ctrl #(
        .NUM_MODES  (NM),
        .NUM_FILTERS(NF),
        .DB_COUNT   (DBC)
`ifdef PMC_CFG_WATCHDOG_EN
        ,
        .CFG_TIMEOUT(100)
`endif
    ) dut (
        .i_sysclk     (i_sysclk),
        .i_rstn       (i_rstn),
        .i_sof        (i_sof),
        .i_cfg_done   (i_cfg_done),
        .i_btn_next   (i_btn_next),
        .i_btn_prev   (i_btn_prev),
        .i_sw_filter  (i_sw_filter),
        .o_cfg_start  (o_cfg_start),
        .o_mode       (o_mode),
        .o_filter_en  (o_filter_en),
        .o_pipe_flush (o_pipe_flush),
        .o_status_leds(o_status_leds)
    );

    always #5 i_sysclk = ~i_sysclk;

    task automatic tick(input int n);
        repeat (n) @(negedge i_sysclk);
    endtask

    task automatic press(input logic nx, input logic pv);
        i_btn_next = nx;
        i_btn_prev = pv;
        tick(DBC + 8);
        i_btn_next = 1'b0;
        i_btn_prev = 1'b0;
        tick(DBC + 8);
    endtask

    task automatic sof_pulse();
        i_sof = 1'b1;
        tick(1);
        i_sof = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        i_rstn = 1'b0;
        tick(3);
        got = {o_cfg_start, o_mode, o_filter_en, o_pipe_flush, o_status_leds};
        n_total++;
        if (got !== 16'h0) $display("FAIL reset_outputs: got %h expected 0000", got);
        else n_pass++;
    endtask

    // Release reset at a negedge; cycle 1 is the first cycle after the release edge.
    task automatic start_cfg(input string tag);
        logic [1:0] got, exp;
        i_rstn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick(1);
            got = {o_cfg_start, o_status_leds[7]};
            exp = {(c == 1), (c >= 11)};
            n_total++;
            if (got !== exp) $display("FAIL %s_cyc%0d cfg_start/led7: got %b expected %b", tag, c, got, exp);
            else n_pass++;
            i_cfg_done = (c == 10);
        end
        n_total++;
        if ({o_mode, o_filter_en} !== 6'h0) $display("FAIL %s_applied: got %h expected 00", tag, {o_mode, o_filter_en});
        else n_pass++;
    endtask

    task automatic test_passthrough();
        logic saw = 1'b0;
        i_sw_filter = 4'b0101;
        for (int c = 0; c < 30; c++) begin
            i_sof = (c == 10 || c == 20);
            tick(1);
            saw |= o_pipe_flush;
        end
        i_sof = 1'b0;
        n_total++;
        if ({saw, o_filter_en} !== 5'b0) $display("FAIL passthrough: got flush=%b en=%b expected 0/0000", saw, o_filter_en);
        else n_pass++;
    endtask

    task automatic test_next_wrap();
        logic [1:0] em [4];
        logic [3:0] ef [4];
        logic [1:0] pm;
        logic [3:0] pf;
        em = '{2'd1, 2'd2, 2'd3, 2'd0};
        ef = '{4'b0101, 4'b0101, 4'b0101, 4'b0000};
        pm = 2'd0;
        pf = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0);
            tick(3);
            i_sof = 1'b1;
            n_total++;
            if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b1, pm, pf})
                $display("FAIL next%0d_pre_sof: got %b expected %b", i, {o_pipe_flush, o_mode, o_filter_en}, {1'b1, pm, pf});
            else n_pass++;
            tick(1);
            i_sof = 1'b0;
            n_total++;
            if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b0, em[i], ef[i]})
                $display("FAIL next%0d_post_sof: got %b expected %b", i, {o_pipe_flush, o_mode, o_filter_en}, {1'b0, em[i], ef[i]});
            else n_pass++;
            pm = em[i];
            pf = ef[i];
        end
    endtask

    task automatic test_filter_mid_flush();
        logic saw = 1'b0;
        press(1'b1, 1'b0);
        tick(2);
        sof_pulse();
        n_total++;
        if ({o_mode, o_filter_en} !== {2'd1, 4'b0101}) $display("FAIL mode1_setup: got %b expected 010101", {o_mode, o_filter_en});
        else n_pass++;
        press(1'b1, 1'b0);
        tick(2);
        i_sw_filter = 4'b0111;
        tick(10);
        n_total++;
        if ({o_pipe_flush, o_mode} !== {1'b1, 2'd1}) $display("FAIL midflush_wait: got %b expected 101", {o_pipe_flush, o_mode});
        else n_pass++;
        sof_pulse();
        n_total++;
        if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b0, 2'd2, 4'b0111})
            $display("FAIL midflush_apply: got %b expected 0100111", {o_pipe_flush, o_mode, o_filter_en});
        else n_pass++;
        n_total++;
        if (o_status_leds !== 8'b1010_0111) $display("FAIL status_leds: got %b expected 10100111", o_status_leds);
        else n_pass++;
        for (int c = 0; c < 30; c++) begin
            i_sof = (c == 15);
            tick(1);
            saw |= o_pipe_flush;
        end
        i_sof = 1'b0;
        n_total++;
        if (saw !== 1'b0) $display("FAIL single_flush: got reflush=%b expected 0", saw);
        else n_pass++;
    endtask

    task automatic test_both_buttons();
        for (int k = 0; k < 3; k++) begin
            i_btn_next = 1'b1;
            i_btn_prev = 1'b1;
            tick(4);
            i_btn_next = 1'b0;
            i_btn_prev = 1'b0;
            tick(4);
        end
        i_btn_next = 1'b1;
        tick(4);
        i_btn_next = 1'b0;
        tick(DBC + 8);
        press(1'b1, 1'b1);
        tick(4);
        n_total++;
        if (o_pipe_flush !== 1'b0) $display("FAIL both_btn_flush: got %b expected 0", o_pipe_flush);
        else n_pass++;
        sof_pulse();
        n_total++;
        if ({o_mode, o_filter_en} !== {2'd2, 4'b0111}) $display("FAIL both_btn_mode: got %b expected 100111", {o_mode, o_filter_en});
        else n_pass++;
    endtask

    task automatic test_net_zero();
        press(1'b1, 1'b0);
        tick(2);
        n_total++;
        if (o_pipe_flush !== 1'b1) $display("FAIL netzero_flush_start: got %b expected 1", o_pipe_flush);
        else n_pass++;
        press(1'b0, 1'b1);
        tick(2);
        n_total++;
        if ({o_pipe_flush, o_mode} !== {1'b1, 2'd2}) $display("FAIL netzero_flush_hold: got %b expected 110", {o_pipe_flush, o_mode});
        else n_pass++;
        sof_pulse();
        tick(10);
        n_total++;
        if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b0, 2'd2, 4'b0111})
            $display("FAIL netzero_done: got %b expected 0100111", {o_pipe_flush, o_mode, o_filter_en});
        else n_pass++;
    endtask

    task automatic test_prev_wrap();
        logic [1:0] em [3];
        logic [3:0] ef [3];
        em = '{2'd1, 2'd0, 2'd3};
        ef = '{4'b0111, 4'b0000, 4'b0111};
        for (int i = 0; i < 3; i++) begin
            press(1'b0, 1'b1);
            tick(2);
            sof_pulse();
            n_total++;
            if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b0, em[i], ef[i]})
                $display("FAIL prev%0d: got %b expected %b", i, {o_pipe_flush, o_mode, o_filter_en}, {1'b0, em[i], ef[i]});
            else n_pass++;
        end
    endtask

    task automatic test_sof_same_cycle();
        i_sw_filter = 4'b0011;
        tick(3);
        n_total++;
        if (o_pipe_flush !== 1'b0) $display("FAIL sw_latency_early: got %b expected 0", o_pipe_flush);
        else n_pass++;
        i_sof = 1'b1;
        tick(1);
        i_sof = 1'b0;
        n_total++;
        if ({o_pipe_flush, o_filter_en} !== {1'b1, 4'b0111}) $display("FAIL sof_not_consumed: got %b expected 10111", {o_pipe_flush, o_filter_en});
        else n_pass++;
        tick(5);
        sof_pulse();
        n_total++;
        if ({o_pipe_flush, o_mode, o_filter_en} !== {1'b0, 2'd3, 4'b0011})
            $display("FAIL sof_next_apply: got %b expected 0110011", {o_pipe_flush, o_mode, o_filter_en});
        else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        logic [15:0] got;
        i_sw_filter = 4'b0110;
        tick(6);
        n_total++;
        if (o_pipe_flush !== 1'b1) $display("FAIL rst_flush_setup: got %b expected 1", o_pipe_flush);
        else n_pass++;
        i_rstn = 1'b0;
        tick(1);
        got = {o_cfg_start, o_mode, o_filter_en, o_pipe_flush, o_status_leds};
        n_total++;
        if (got !== 16'h0) $display("FAIL rst_mid_flush: got %h expected 0000", got);
        else n_pass++;
        start_cfg("recfg");
        tick(10);
        n_total++;
        if ({o_pipe_flush, o_mode, o_filter_en} !== 7'b0) $display("FAIL recfg_idle: got %b expected 0000000", {o_pipe_flush, o_mode, o_filter_en});
        else n_pass++;
    endtask

`ifdef PMC_CFG_WATCHDOG_EN
    task automatic test_watchdog();
        logic [1:0] got, exp;
        i_rstn = 1'b0;
        tick(2);
        i_rstn = 1'b1;
        for (int c = 1; c <= 210; c++) begin
            tick(1);
            got = {o_cfg_start, o_status_leds[7]};
            exp = {(c == 1 || c == 103 || c == 205), 1'b0};
            n_total++;
            if (got !== exp) $display("FAIL watchdog_cyc%0d: got %b expected %b", c, got, exp);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        start_cfg("cfg");
        test_passthrough();
        test_next_wrap();
        test_filter_mid_flush();
        test_both_buttons();
        test_net_zero();
        test_prev_wrap();
        test_sof_same_cycle();
        test_reset_mid_flush();
`ifdef PMC_CFG_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_mode_ctrl.md
# pipe_mode_ctrl

Board-input to pipeline-control bridge for the multi-filter video pipeline. It starts camera configuration after reset and waits for the configuration to complete. It cycles through `NUM_MODES` processing modes with next/prev buttons and gates `NUM_FILTERS` filter-enable switches. Every mode or filter change is applied frame-synchronously, behind a pipeline flush held until start-of-frame.

## Interface
- `NUM_MODES`, 4: number of modes, ≥2; mode 0 is passthrough.
- `NUM_FILTERS`, 4: number of filter-enable switches/outputs, 1..8.
- `DB_COUNT`, 500_000: debounce stable-count in `i_sysclk` cycles (20 ms at 25 MHz).
- `CFG_TIMEOUT`, 2_500_000: cycles to wait for `i_cfg_done` before a retry (only with `PMC_CFG_WATCHDOG_EN`).
- `MW`, derived: `$clog2(NUM_MODES)`.

Ports:
- `i_sysclk` in 1: system clock.
- `i_rstn` in 1: reset i_rstn, synchronous, active-low; clock i_sysclk.
- `i_sof` in 1: start-of-frame pulse, `i_sysclk` domain.
- `i_cfg_done` in 1: camera configuration complete, level or pulse.
- `i_btn_next` in 1: raw button, advance mode.
- `i_btn_prev` in 1: raw button, previous mode.
- `i_sw_filter` in NUM_FILTERS: raw asynchronous switches.
- `o_cfg_start` out 1: one-cycle configuration start pulse.
- `o_mode` out MW: applied mode.
- `o_filter_en` out NUM_FILTERS: applied filter enables.
- `o_pipe_flush` out 1: pipeline flush request.
- `o_status_leds` out 8: status display.

## Operation
- Main FSM states and transitions:
  - CFG_START → CFG_WAIT: unconditional, one cycle, `o_cfg_start`=1.
  - CFG_WAIT → ACTIVE: on `i_cfg_done`=1.
  - ACTIVE → FLUSH: on a pending change.
  - FLUSH → ACTIVE: on `i_sof`.
- Buttons: debounced, then a rising edge produces a one-cycle press pulse.
- Switches: 2-FF synchronised.
- Pending registers `pend_mode` and `pend_en` track the requested settings:
  - next: `pend_mode`+1, wraps NUM_MODES-1→0.
  - prev: `pend_mode`-1, wraps 0→NUM_MODES-1.
  - next and prev pressed in the same cycle: both ignored.
  - `pend_en` = synchronised switches AND (`pend_mode`≠0). Passthrough forces 0.
- Change detect: (`pend_mode`,`pend_en`) ≠ (`o_mode`,`o_filter_en`), evaluated in ACTIVE only.
- In FLUSH: `o_pipe_flush`=1. Further changes only update the pending registers. On the `i_sof` cycle, `o_mode`/`o_filter_en` load the pending values.
- A change whose net effect returns to the applied values (e.g. next then prev) still completes the flush at the next `i_sof`.
- Button presses and switch changes during CFG_START/CFG_WAIT update the pending registers only. Any resulting difference flushes on entry to ACTIVE.
- `o_status_leds`:
  - [3:0]: `o_filter_en` zero-extended/truncated to 4 bits.
  - [6:4]: `o_mode` zero-extended/truncated to 3 bits.
  - [7]: 1 when FSM is ACTIVE or FLUSH.

## Timing
- Reset values: `o_cfg_start`=0, `o_mode`=0, `o_filter_en`=0, `o_pipe_flush`=0, `o_status_leds`=0. FSM=CFG_START, all pending/sync/edge registers 0.
- `o_cfg_start` is high exactly in the first cycle after `i_rstn` is released.
- Button: raw stable for DB_COUNT cycles → press pulse +2 cycles → `pend_mode` updates the next cycle.
- Switch → `pend_en`: 3 cycles.
- Change detected in ACTIVE at cycle N → FSM=FLUSH and `o_pipe_flush`=1 at N+1.
- `i_sof` sampled high in FLUSH at cycle M → new `o_mode`/`o_filter_en` at M+1, `o_pipe_flush`=0 at M+1.
- `i_sof` in the same cycle as change detection in ACTIVE is not consumed; the flush waits for the following `i_sof`.
- Reset mid-FLUSH or mid-CFG: all outputs return to reset values and configuration restarts.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `PMC_CFG_WATCHDOG_EN` defined:
  - CFG_WAIT counts cycles; at CFG_TIMEOUT without `i_cfg_done`, it returns to CFG_START.
  - That re-pulses `o_cfg_start` and increments a 4-bit saturating retry count.
  - LED[7] blinks with count bit[22] while in CFG_WAIT after ≥1 retry.
- Undefined: CFG_WAIT waits indefinitely, with no counter logic.

## Structure
- Package `pmc_pkg`: FSM state enum (CFG_START, CFG_WAIT, ACTIVE, FLUSH), `MODE_PASSTHROUGH`=0, LED field offsets.
- Sub-module `btn_pulse`: wraps the existing `debounce`, plus the edge detector giving a one-cycle press pulse. Instantiated twice.
- Everything else is in `pipe_mode_ctrl`.

## Test plan
- Reset release, `i_cfg_done` pulsed at cycle 10 → `o_cfg_start` high cycle 1 only; LED[7]=1 from cycle 11; `o_mode`=0, `o_filter_en`=0.
- ACTIVE, `i_sw_filter`=4'b0101, mode 0 → no flush; `o_filter_en` stays 0.
- Next pressed 3×, `i_sof` every 1000 cycles, NUM_MODES=4 → `o_mode` 1,2,3. Each change needs flush high until the next `i_sof` and update exactly 1 cycle after it. A 4th press wraps to 0.
- Mode 2, switches 0101→0111 mid-flush-wait → single flush; after `i_sof`, `o_filter_en`=0111; `o_status_leds`=8'b1010_0111.
- Next and prev pressed in the same cycle, plus 5 ms bounce glitches → no mode change, no flush.
- `PMC_CFG_WATCHDOG_EN`, CFG_TIMEOUT=100, `i_cfg_done` never → `o_cfg_start` pulses at cycles 1, 103, 205…; reset mid-FLUSH → all outputs 0 next cycle.
